rotary_encoder_decoder: RTL and testbench
=========================================

Name: rotary_encoder_decoder

Overview:
- Produces the 5-bit `enc` position bus that the LED control logic consumes.
- Decodes a mechanical quadrature rotary encoder (A/B channels plus push switch) into that bounded position count.
- Raw board inputs are synchronized, debounced and Gray-decoded, with one count per full detent.
- Also emits a one-cycle step pulse, the last direction, and an illegal-transition flag.

Parameters:
- DEBOUNCE_CYCLES, 100_000, consecutive clocks an input must hold a new level before the filtered copy accepts it (1 ms at 100 MHz).
- MAX_POS, 14, highest position value; range is 0..MAX_POS, and MAX_POS must be ≤ 31.
- WRAP, 1, 1 = wrap around at both ends; 0 = saturate at both ends.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enc_a  input  1  raw encoder channel A; asynchronous; idles high at a detent.
- enc_b  input  1  raw encoder channel B; asynchronous; idles high at a detent.
- enc_btn  input  1  raw push switch; asynchronous; 1 = pressed.
- enc  output  5  current position, 0..MAX_POS.
- step  output  1  one-clock pulse on every change of `enc`, except a button clear.
- dir  output  1  direction of the last counted detent; 1 = CW, 0 = CCW.
- err  output  1  one-clock pulse on an illegal quadrature transition.

Behaviour:
- Reset (async, rst=1):
  - enc=0, step=0, dir=0, err=0.
  - Sync flops and filtered A/B = 1; filtered btn = 0.
  - Debounce counters = 0; phase accumulator q = 0.
  - Outputs are valid the first clock after rst deasserts.
  - Reset mid-rotation discards the partial detent.
- Synchronizer:
  - 2-flop synchronizer on each raw input.
  - No logic reads an unsynchronized input.
- Debounce, per input, with its own counter of width ≥ clog2(DEBOUNCE_CYCLES+1):
  - While synced ≠ filtered, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, filtered takes the synced value and the counter clears.
  - Any clock where synced = filtered clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Latency: a stable raw edge reaches the filtered value DEBOUNCE_CYCLES+2 clocks later, ±1 clock depending on sample phase.
- Quadrature state, ab = {filtered A, filtered B}:
  - Detent is 11.
  - CW sequence: 11 → 01 → 00 → 10 → 11.
  - CCW sequence: 11 → 10 → 00 → 01 → 11.
  - Registered previous ab is compared every clock.
- Phase accumulator q, signed, range −3..+3:
  - A valid CW transition increments q; a valid CCW transition decrements q.
  - On a transition into 11 with q=+3 (prior value): count CW, q ← 0.
  - On a transition into 11 with q=−3 (prior value): count CCW, q ← 0.
  - On a transition into 11 with any other q (bounce or reversal): q ← 0, no count.
  - Illegal transition (both bits change in one clock, 00↔11 or 01↔10): q ← 0, err=1 for one clock, no count.
  - No change: hold.
- Counting:
  - A CW count gives enc+1, step=1, dir=1.
  - A CCW count gives enc−1, step=1, dir=0.
  - enc and step update on the clock after the filtered ab enters 11.
- Boundaries:
  - CW at enc=MAX_POS: WRAP=1 gives enc=0 with step; WRAP=0 holds enc, no step, dir still updated.
  - CCW at enc=0: WRAP=1 gives enc=MAX_POS with step; WRAP=0 holds enc, no step, dir still updated.
  - enc never leaves 0..MAX_POS.
- Button:
  - A rising edge of filtered btn sets enc=0 next clock, with no step and dir unchanged.
  - If it coincides with a detent count, the button wins: enc=0, step=0, q ← 0.
  - Holding the button does not block rotation counting after the edge.
- Output registers: step and err are registered and high for exactly one clock; enc and dir are registered.

Test Plan (DEBOUNCE_CYCLES=4, MAX_POS=14, WRAP=1 unless noted):
- Post-reset CW: hold rst 3 clocks, release, drive one full CW cycle (11,01,00,10,11), each level held 10 clocks → enc 0→1 once, one step pulse, dir=1, err never high.
- Wrap-around: 15 CW detents from 0 → enc reaches 14, then 0 with step. Then 1 CCW detent → enc=14, dir=0.
- Saturation (WRAP=0): CCW detent at enc=0 → enc stays 0, no step, dir=0. At enc=14, a CW detent → enc stays 14, no step.
- Bounce and glitch rejection:
  - Toggle A for 2-clock glitches during a stable 11 → no filtered change, enc unchanged.
  - Partial CW 11→01→11 → q clears, enc unchanged, no step.
- Illegal transition: force filtered ab 01→10 in one clock (both raw bits change together) → err pulse 1 clock, q=0. A following full CW cycle counts normally.
- Button and reset:
  - At enc=7, press button ≥6 clocks → enc=0, no step.
  - Pressing the button in the same clock as a completed CW detent → enc=0.
  - Asserting rst mid-cycle at ab=00 → enc=0 immediately; after release, the remaining 10→11 does not count.

Source files
------------

// File: rtl/rotary_encoder_decoder.sv
// Quadrature rotary encoder front end: synchronise, debounce and Gray-decode the
// A/B/button inputs into a bounded position with step, direction and error pulses.
module rotary_encoder_decoder #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int MAX_POS         = 14,
  parameter bit WRAP            = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_btn,
  output logic [4:0] enc,
  output logic       step,
  output logic       dir,
  output logic       err
);

  localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       IDLE_LEVELS = 3'b110;  // {A, B, btn} at rest
  localparam logic [4:0]       MAX_ENC     = 5'(MAX_POS);

  typedef enum logic [1:0] {MV_NONE, MV_CW, MV_CCW, MV_ILLEGAL} move_e;

  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [1:0]       ab, prev_ab_q;
  logic signed [2:0] q_q, q_d;
  logic             btn_prev_q;
  logic [4:0]       enc_q, enc_d;
  logic             step_q, step_d, dir_q, dir_d, err_q, err_d;
  move_e            move;
  logic             into_det, count_cw, count_ccw, btn_rise;

  assign raw = {enc_a, enc_b, enc_btn};
  assign ab  = filt_q[2:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_LEVELS;
      sync2_q <= IDLE_LEVELS;
    end else begin
      // NOTE: non-blocking so sync2 captures the old sync1, giving two real stages.
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // A new level must be seen on DEBOUNCE_CYCLES consecutive clocks to be accepted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // NOTE: defaults first so every path assigns, otherwise latches are inferred.
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) filt_d[i] = sync2_q[i];
        else                      cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= IDLE_LEVELS;
      // NOTE: the counter array is reset explicitly; it is control state, not storage.
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    case ({prev_ab_q, ab})
      4'b1101, 4'b0100, 4'b0010, 4'b1011: move = MV_CW;
      4'b1110, 4'b1000, 4'b0001, 4'b0111: move = MV_CCW;
      4'b1100, 4'b0011, 4'b0110, 4'b1001: move = MV_ILLEGAL;
      default:                            move = MV_NONE;
    endcase
  end

  assign into_det  = (ab == 2'b11) && (prev_ab_q != 2'b11) && (move != MV_ILLEGAL);
  assign count_cw  = into_det && (q_q == 3'sd3);
  assign count_ccw = into_det && (q_q == -3'sd3);
  assign btn_rise  = filt_q[0] && !btn_prev_q;

  always_comb begin
    q_d    = q_q;
    enc_d  = enc_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = (move == MV_ILLEGAL);

    if (move == MV_ILLEGAL || into_det) q_d = '0;
    else if (move == MV_CW)             q_d = q_q + 3'sd1;
    else if (move == MV_CCW)            q_d = q_q - 3'sd1;

    if (count_cw) begin
      dir_d = 1'b1;
      if (enc_q != MAX_ENC) begin
        enc_d  = enc_q + 5'd1;
        step_d = 1'b1;
      end else if (WRAP) begin
        enc_d  = '0;
        step_d = 1'b1;
      end
    end else if (count_ccw) begin
      dir_d = 1'b0;
      if (enc_q != '0) begin
        enc_d  = enc_q - 5'd1;
        step_d = 1'b1;
      end else if (WRAP) begin
        enc_d  = MAX_ENC;
        step_d = 1'b1;
      end
    end

    // A button edge overrides any detent counted in the same clock.
    if (btn_rise) begin
      enc_d  = '0;
      step_d = 1'b0;
      dir_d  = dir_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_q  <= 2'b11;
      q_q        <= '0;
      btn_prev_q <= 1'b0;
      enc_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_ab_q  <= ab;
      q_q        <= q_d;
      btn_prev_q <= filt_q[0];
      enc_q      <= enc_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign enc  = enc_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Scoreboard bench: a wrapping and a saturating decoder share one stimulus stream,
// each with its own reference model and queue of expected step results.
module tb_rotary_encoder_decoder;

  localparam int MAXP  = 14;
  localparam bit WRAPS [2] = '{1'b1, 1'b0};

  typedef struct packed {
    logic [4:0] enc;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b1, enc_b = 1'b1, enc_btn = 1'b0;
  logic [4:0] enc_w, enc_s;
  logic       step_w, step_s, dir_w, dir_s, err_w, err_s;
  logic       err_prev_w = 1'b0, err_prev_s = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   pos  [2];
  bit   mdir [2];
  int   err_cnt_w = 0, err_cnt_s = 0;
  int   exp_err = 0;
  exp_t q_w [$];
  exp_t q_s [$];

  always #5 clk = ~clk;

  rotary_encoder_decoder #(.DEBOUNCE_CYCLES(4), .MAX_POS(MAXP), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .enc(enc_w), .step(step_w), .dir(dir_w), .err(err_w)
  );

  rotary_encoder_decoder #(.DEBOUNCE_CYCLES(4), .MAX_POS(MAXP), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .enc(enc_s), .step(step_s), .dir(dir_s), .err(err_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model for one counted detent (or a detent masked by a button edge).
  task automatic model_count(input bit cw, input bit btn);
    bit   moved;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      moved = 1'b1;
      if (btn) begin
        pos[k] = 0;
      end else begin
        mdir[k] = cw;
        if (cw) begin
          if (pos[k] == MAXP) begin
            if (WRAPS[k]) pos[k] = 0; else moved = 1'b0;
          end else pos[k]++;
        end else begin
          if (pos[k] == 0) begin
            if (WRAPS[k]) pos[k] = MAXP; else moved = 1'b0;
          end else pos[k]--;
        end
        if (moved) begin
          e.enc = 5'(pos[k]);
          e.dir = mdir[k];
          if (k == 0) q_w.push_back(e); else q_s.push_back(e);
        end
      end
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic btn, input int n);
    enc_a   = a;
    enc_b   = b;
    enc_btn = btn;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cw_detent(input bit btn_at_end);
    drive(1'b0, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 10);
    model_count(1'b1, btn_at_end);
    drive(1'b1, 1'b1, btn_at_end, 10);
    if (btn_at_end) drive(1'b1, 1'b1, 1'b0, 10);
  endtask

  task automatic ccw_detent();
    drive(1'b1, 1'b0, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 1'b0, 10);
    model_count(1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 10);
  endtask

  task automatic press(input int n);
    pos[0] = 0;
    pos[1] = 0;
    drive(1'b1, 1'b1, 1'b1, n);
    drive(1'b1, 1'b1, 1'b0, 10);
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_enc_w"}, enc_w, pos[0]);
    check({tag, "_enc_s"}, enc_s, pos[1]);
    check({tag, "_dir_w"}, dir_w, mdir[0]);
    check({tag, "_dir_s"}, dir_s, mdir[1]);
  endtask

  // Scoreboard monitors: each step pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (step_w) begin
        if (q_w.size() == 0) check("step_w_unexpected", enc_w, 5'h1f);
        else begin
          e = q_w.pop_front();
          check("step_w_enc", enc_w, e.enc);
          check("step_w_dir", dir_w, e.dir);
        end
      end
      if (step_s) begin
        if (q_s.size() == 0) check("step_s_unexpected", enc_s, 5'h1f);
        else begin
          e = q_s.pop_front();
          check("step_s_enc", enc_s, e.enc);
          check("step_s_dir", dir_s, e.dir);
        end
      end
      if (err_w) err_cnt_w++;
      if (err_s) err_cnt_s++;
      if (err_w && err_prev_w) check("err_w_width", 2, 1);
      if (err_s && err_prev_s) check("err_s_width", 2, 1);
      if (enc_w > MAXP) check("enc_w_range", enc_w, MAXP);
      if (enc_s > MAXP) check("enc_s_range", enc_s, MAXP);
    end
    err_prev_w <= err_w;
    err_prev_s <= err_s;
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      pos[k]  = 0;
      mdir[k] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_enc", enc_w, 0);
    check("rst_step", step_w, 0);
    check("rst_dir", dir_w, 0);
    check("rst_err", err_w, 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 10);

    cw_detent(1'b0);
    check_pos("first_cw");

    repeat (14) cw_detent(1'b0);
    check_pos("after_15_cw");

    ccw_detent();
    check_pos("ccw_from_0");

    cw_detent(1'b0);
    press(8);
    check_pos("btn_keeps_dir");
    ccw_detent();
    check_pos("ccw_at_0");

    repeat (5) begin
      drive(1'b0, 1'b1, 1'b0, 2);
      drive(1'b1, 1'b1, 1'b0, 5);
    end
    check_pos("glitch");

    drive(1'b0, 1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 1'b0, 10);
    check_pos("partial_cw");

    drive(1'b0, 1'b1, 1'b0, 10);
    drive(1'b1, 0, 1'b0, 10);
    exp_err++;
    check("illegal_err_w", err_cnt_w, exp_err);
    check("illegal_err_s", err_cnt_s, exp_err);
    drive(1'b1, 1'b1, 1'b0, 10);
    check_pos("illegal_no_count");
    cw_detent(1'b0);
    check_pos("cw_after_illegal");

    press(8);
    repeat (7) cw_detent(1'b0);
    check_pos("at_seven");
    press(8);
    check_pos("btn_clear");

    repeat (2) cw_detent(1'b0);
    cw_detent(1'b1);
    check_pos("btn_with_detent");

    cw_detent(1'b0);
    drive(1'b0, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 10);
    rst = 1'b1;
    #1;
    check("midrst_enc_w", enc_w, 0);
    check("midrst_enc_s", enc_s, 0);
    check("midrst_q_w_empty", q_w.size(), 0);
    for (int k = 0; k < 2; k++) begin
      pos[k]  = 0;
      mdir[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err++;  // filtered ab jumps 11 -> 00 once the held raw 00 is accepted
    drive(1'b0, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 1'b0, 10);
    check_pos("after_midrst");

    check("err_total_w", err_cnt_w, exp_err);
    check("err_total_s", err_cnt_s, exp_err);
    check("q_w_drained", q_w.size(), 0);
    check("q_s_drained", q_s.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
